// File: rtl/drum_accumulator.sv
// Saturating frame accumulator behind the DRUM multiplier: sums LEN (or fewer,
// on in_last) unsigned products and presents sum/count/saturation on a held handshake.
module drum_accumulator #(
  parameter int N_BITS = 4,
  parameter int M_BITS = 4,
  parameter int P_W    = N_BITS + M_BITS,
  parameter int ACC_W  = 16,
  parameter int LEN    = 4,
  parameter int CNT_W  = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P_W-1:0]   in_product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_next;
  logic             overflow;
  logic             take;
  logic             close;

  // One guard bit catches the carry out; a carry clamps the sum to all ones.
  always_comb begin
    sum_wide = {1'b0, acc} + (ACC_W + 1)'(in_product);
    overflow = sum_wide[ACC_W];
    acc_next = overflow ? '1 : sum_wide[ACC_W-1:0];
  end

  assign in_ready = (state == ACCUM);
  assign take     = in_valid & in_ready;
  assign close    = take & ((cnt == LAST_CNT) | in_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (close) state_next = HOLD;
      HOLD:  if (out_valid & out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Closing transfer publishes the updated totals and restarts the frame in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (close) begin
        out_sum   <= acc_next;
        out_count <= cnt + 1'b1;
        out_sat   <= sat | overflow;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        sat       <= 1'b0;
      end else if (take) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
        sat <= sat | overflow;
      end
      if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_drum_accumulator.sv
// Directed bench for drum_accumulator: a default instance and a small ACC_W=10/LEN=8
// instance, with expected frame results queued at stimulus time and checked on output.
module tb_drum_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        v0 = 1'b0, l0 = 1'b0, or0 = 1'b0;
  logic        r0, ov0, sat0;
  logic [7:0]  p0 = '0;
  logic [15:0] sum0;
  logic [2:0]  cnt0;

  logic        v1 = 1'b0, l1 = 1'b0, or1 = 1'b0;
  logic        r1, ov1, sat1;
  logic [7:0]  p1 = '0;
  logic [9:0]  sum1;
  logic [3:0]  cnt1;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] count;
    logic [31:0] sat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks   = 0;
  int failures = 0;

  int m_sum[2];
  int m_cnt[2];
  int m_sat[2];

  drum_accumulator dut0 (
    .clk(clk), .rst(rst),
    .in_valid(v0), .in_ready(r0), .in_product(p0), .in_last(l0),
    .out_valid(ov0), .out_ready(or0),
    .out_sum(sum0), .out_count(cnt0), .out_sat(sat0)
  );

  drum_accumulator #(.ACC_W(10), .LEN(8)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(r1), .in_product(p1), .in_last(l1),
    .out_valid(ov1), .out_ready(or1),
    .out_sum(sum1), .out_count(cnt1), .out_sat(sat1)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_sum[s] = 0;
      m_cnt[s] = 0;
      m_sat[s] = 0;
    end
  endtask

  // Reference behaviour of one accepted product, pushing a frame result on close.
  task automatic model_accept(input int sel, input int p, input logic last);
    int maxv;
    int lenv;
    exp_t e;
    maxv = (sel == 0) ? 65535 : 1023;
    lenv = (sel == 0) ? 4 : 8;
    m_sum[sel] = m_sum[sel] + p;
    if (m_sum[sel] > maxv) begin
      m_sum[sel] = maxv;
      m_sat[sel] = 1;
    end
    m_cnt[sel]++;
    if (m_cnt[sel] == lenv || last) begin
      e.sum   = m_sum[sel];
      e.count = m_cnt[sel];
      e.sat   = m_sat[sel];
      if (sel == 0) q0.push_back(e);
      else q1.push_back(e);
      m_sum[sel] = 0;
      m_cnt[sel] = 0;
      m_sat[sel] = 0;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the product is taken.
  task automatic apply_stimulus(input int sel, input logic [7:0] p, input logic last);
    int n;
    if (sel == 0) begin v0 = 1'b1; p0 = p; l0 = last; end
    else begin v1 = 1'b1; p1 = p; l1 = last; end
    n = 0;
    while (!((sel == 0) ? r0 : r1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $error("[TB] FAIL ready_timeout sel=%0d observed=in_ready_low expected=in_ready_high", sel);
    end else begin
      model_accept(sel, p, last);
    end
    @(negedge clk);
    if (sel == 0) begin v0 = 1'b0; l0 = 1'b0; end
    else begin v1 = 1'b0; l1 = 1'b0; end
  endtask

  // Scoreboard: every output transfer must match the oldest queued frame.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst && ov0 && or0) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $error("[TB] FAIL unexpected_frame0 observed=sum%0d expected=no_output", sum0);
      end else begin
        e = q0.pop_front();
        check_output("frame0_sum", 32'(sum0), e.sum);
        check_output("frame0_count", 32'(cnt0), e.count);
        check_output("frame0_sat", 32'(sat0), e.sat);
      end
    end
    if (!rst && ov1 && or1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $error("[TB] FAIL unexpected_frame1 observed=sum%0d expected=no_output", sum1);
      end else begin
        e = q1.pop_front();
        check_output("frame1_sum", 32'(sum1), e.sum);
        check_output("frame1_count", 32'(cnt1), e.count);
        check_output("frame1_sat", 32'(sat1), e.sat);
      end
    end
  end

  initial begin
    model_reset();

    // Reset held for 3 cycles with random inputs.
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      v0 = 1'($urandom); p0 = 8'($urandom); l0 = 1'($urandom); or0 = 1'($urandom);
      v1 = 1'($urandom); p1 = 8'($urandom); l1 = 1'($urandom); or1 = 1'($urandom);
    end
    v0 = 1'b0; l0 = 1'b0; or0 = 1'b1;
    v1 = 1'b0; l1 = 1'b0; or1 = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check_output("reset_out_valid", 32'(ov0), 0);
    check_output("reset_out_sum", 32'(sum0), 0);
    check_output("reset_out_count", 32'(cnt0), 0);
    check_output("reset_out_sat", 32'(sat0), 0);
    check_output("reset_in_ready", 32'(r0), 1);
    check_output("reset_out_valid1", 32'(ov1), 0);
    check_output("reset_in_ready1", 32'(r1), 1);

    // Full frame 6,2,15,225 -> 248; in_ready low for exactly the HOLD cycle.
    apply_stimulus(0, 8'd6, 1'b0);
    apply_stimulus(0, 8'd2, 1'b0);
    apply_stimulus(0, 8'd15, 1'b0);
    apply_stimulus(0, 8'd225, 1'b0);
    check_output("full_out_valid_high", 32'(ov0), 1);
    check_output("full_in_ready_low", 32'(r0), 0);
    @(negedge clk);
    check_output("full_out_valid_pulse", 32'(ov0), 0);
    check_output("full_in_ready_back", 32'(r0), 1);

    // Early close with idle gap, then a fresh frame starting from zero.
    apply_stimulus(0, 8'd3, 1'b0);
    repeat (2) @(negedge clk);
    apply_stimulus(0, 8'd10, 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 8'd1, 1'b0);

    // Saturation on the narrow instance, then a clean frame of ones.
    for (int i = 0; i < 8; i++) apply_stimulus(1, 8'd225, 1'b0);
    for (int i = 0; i < 8; i++) apply_stimulus(1, 8'd1, 1'b0);

    // Backpressure: result held for 5 cycles while a product waits upstream.
    or0 = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(0, 8'd1, 1'b0);
    v0 = 1'b1;
    p0 = 8'd7;
    for (int i = 0; i < 5; i++) begin
      check_output("bp_in_ready_low", 32'(r0), 0);
      check_output("bp_out_valid_held", 32'(ov0), 1);
      check_output("bp_sum_stable", 32'(sum0), 4);
      @(negedge clk);
    end
    or0 = 1'b1;
    apply_stimulus(0, 8'd7, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 8'd1, 1'b0);
    repeat (2) @(negedge clk);

    // Asynchronous reset between edges discards a partial frame.
    apply_stimulus(0, 8'd5, 1'b0);
    apply_stimulus(0, 8'd5, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst_sum", 32'(sum0), 0);
    check_output("async_rst_count", 32'(cnt0), 0);
    check_output("async_rst_sum1", 32'(sum1), 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    apply_stimulus(0, 8'd1, 1'b0);
    apply_stimulus(0, 8'd2, 1'b0);
    apply_stimulus(0, 8'd3, 1'b0);
    apply_stimulus(0, 8'd4, 1'b0);

    repeat (4) @(negedge clk);
    check_output("queue0_drained", 32'(q0.size()), 0);
    check_output("queue1_drained", 32'(q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
